// File: rtl/oserdes_ctrl.sv
// Startup and streaming sequencer for one 10:1 OSERDESE2 lane.
// Holds the serializer in reset until the clock generator locks.
// It then releases reset, lets the serializer settle with OCE low,
// and sends a training word with OCE high.
// After training it streams valid/ready data, inserting an idle word
// whenever the upstream source has nothing to send.
module oserdes_ctrl #(
    parameter int               WIDTH         = 10,
    parameter int               RST_CYCLES    = 4,
    parameter int               SETTLE_CYCLES = 8,
    parameter int               TRAIN_CYCLES  = 64,
    parameter logic [WIDTH-1:0] TRAIN_WORD    = 10'b1101010100,
    parameter logic [WIDTH-1:0] IDLE_WORD     = 10'b1101010100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] ser_data,
    output logic             ser_rst,
    output logic             ser_oce,
    output logic             running,
    output logic [15:0]      underflow_cnt
);

    // The phase counter must hold the longest phase length minus one.
    localparam int MAX_AB = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_ALL = (MAX_AB > TRAIN_CYCLES) ? MAX_AB : TRAIN_CYCLES;
    localparam int CW = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TRAIN_LOAD  = CW'(TRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TRAIN  = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] ser_data_q;
    logic [WIDTH-1:0] ser_data_d;
    logic [15:0]      underflow_cnt_q;
    logic [15:0]      underflow_cnt_d;

    // Next-state, phase counter, output word and underflow counter.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ser_data_d      = ser_data_q;
        underflow_cnt_d = underflow_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // The serializer must never see the zero word once out of reset.
                ser_data_d = TRAIN_WORD;
                if (locked) begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_RESET: begin
                ser_data_d = TRAIN_WORD;
                if (!locked) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = ST_RESET;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end

            ST_SETTLE: begin
                ser_data_d = TRAIN_WORD;
                if (!locked) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_TRAIN;
                    cnt_d   = TRAIN_LOAD;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end

            ST_TRAIN: begin
                ser_data_d = TRAIN_WORD;
                if (!locked) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_TRAIN;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end

            ST_RUN: begin
                // A word offered on the edge that loses lock is still taken.
                if (s_valid) begin
                    ser_data_d = s_data;
                end else begin
                    ser_data_d = IDLE_WORD;
                    if (underflow_cnt_q != 16'hFFFF) begin
                        underflow_cnt_d = underflow_cnt_q + 16'd1;
                    end else begin
                        underflow_cnt_d = underflow_cnt_q;
                    end
                end
                if (!locked) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
                cnt_d = CNT_ZERO;
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = CNT_ZERO;
                ser_data_d = TRAIN_WORD;
            end
        endcase
    end

    // State, counter and data registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= CNT_ZERO;
            ser_data_q      <= {WIDTH{1'b0}};
            underflow_cnt_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ser_data_q      <= ser_data_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    // Moore decode straight from the registered state.
    assign ser_rst       = (state_q == ST_IDLE) || (state_q == ST_RESET);
    assign ser_oce       = (state_q == ST_TRAIN) || (state_q == ST_RUN);
    assign running       = (state_q == ST_RUN);
    assign s_ready       = (state_q == ST_RUN);
    assign ser_data      = ser_data_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_oserdes_ctrl.sv
// Directed testbench for oserdes_ctrl with default parameters.
// "cycle k" means the interval after the k-th rising edge, counted
// from the edge that first samples locked=1 (edge 0).
// In that numbering RESET covers cycles 1-4, SETTLE 5-12, TRAIN 13-76
// and RUN starts at cycle 77.
module tb_oserdes_ctrl;

    localparam logic [9:0] TW = 10'b1101010100;
    localparam logic [9:0] IW = 10'b1101010100;

    logic        clk;
    logic        rst_n;
    logic        locked;
    logic [9:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  ser_data;
    logic        ser_rst;
    logic        ser_oce;
    logic        running;
    logic [15:0] underflow_cnt;

    int tests_run;
    int tests_failed;

    oserdes_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .locked       (locked),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ser_data     (ser_data),
        .ser_rst      (ser_rst),
        .ser_oce      (ser_oce),
        .running      (running),
        .underflow_cnt(underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        locked  = 1'b0;
        s_data  = 10'd0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ser_rst, ser_oce, s_ready, running} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rst/oce/rdy/run=%b want 1000",
                     {ser_rst, ser_oce, s_ready, running});
        end
        tests_run++;
        if (ser_data !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 000", ser_data);
        end
        tests_run++;
        if (underflow_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_uf: got %h want 0000", underflow_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Lock at edge 0 and check every cycle up to the first RUN cycle.
    task automatic test_startup();
        logic [3:0] exp_ctrl;
        locked = 1'b1;
        for (int k = 1; k <= 77; k++) begin
            step();
            exp_ctrl = {(k <= 4), (k >= 13), (k >= 77), (k >= 77)};
            tests_run++;
            if ({ser_rst, ser_oce, s_ready, running} !== exp_ctrl) begin
                tests_failed++;
                $display("FAIL startup_ctrl c%0d: got %b want %b", k,
                         {ser_rst, ser_oce, s_ready, running}, exp_ctrl);
            end
            tests_run++;
            if (ser_data !== TW) begin
                tests_failed++;
                $display("FAIL startup_data c%0d: got %h want %h", k, ser_data, TW);
            end
        end
        tests_run++;
        if (underflow_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL startup_uf: got %h want 0000", underflow_cnt);
        end
    endtask

    task automatic test_stream();
        logic [9:0] words [3];
        words[0] = 10'h2AA;
        words[1] = 10'h155;
        words[2] = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            s_data  = words[i];
            s_valid = 1'b1;
            step();
            tests_run++;
            if (ser_data !== words[i]) begin
                tests_failed++;
                $display("FAIL stream_word%0d: got %h want %h", i, ser_data, words[i]);
            end
        end
        s_valid = 1'b0;
        tests_run++;
        if (underflow_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL stream_uf: got %h want 0000", underflow_cnt);
        end
    endtask

    task automatic test_underflow();
        s_valid = 1'b0;
        s_data  = 10'h0F0;
        for (int i = 1; i <= 5; i++) begin
            step();
            tests_run++;
            if (ser_data !== IW) begin
                tests_failed++;
                $display("FAIL underflow_data%0d: got %h want %h", i, ser_data, IW);
            end
            tests_run++;
            if (underflow_cnt !== 16'(i)) begin
                tests_failed++;
                $display("FAIL underflow_cnt%0d: got %h want %h", i, underflow_cnt, 16'(i));
            end
        end
    endtask

    // One-cycle lock loss in RUN with a word accepted on the same edge.
    task automatic test_lock_loss();
        logic [3:0] exp_ctrl;
        s_data  = 10'h0F0;
        s_valid = 1'b1;
        locked  = 1'b0;
        step();
        s_valid = 1'b0;
        tests_run++;
        if ({ser_rst, ser_oce, s_ready, running} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL lockloss_ctrl: got %b want 1000",
                     {ser_rst, ser_oce, s_ready, running});
        end
        tests_run++;
        if (ser_data !== 10'h0F0) begin
            tests_failed++;
            $display("FAIL lockloss_data: got %h want 0f0", ser_data);
        end
        tests_run++;
        if (underflow_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL lockloss_uf: got %h want 0005", underflow_cnt);
        end
        locked = 1'b1;
        for (int k = 1; k <= 77; k++) begin
            step();
            exp_ctrl = {(k <= 4), (k >= 13), (k >= 77), (k >= 77)};
            tests_run++;
            if ({ser_rst, ser_oce, s_ready, running} !== exp_ctrl) begin
                tests_failed++;
                $display("FAIL relock_ctrl c%0d: got %b want %b", k,
                         {ser_rst, ser_oce, s_ready, running}, exp_ctrl);
            end
        end
        tests_run++;
        if (underflow_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL relock_uf: got %h want 0005", underflow_cnt);
        end
    endtask

    // Lock loss at cycle 40 (TRAIN), relock sampled at edge 45.
    task automatic test_abort_train();
        logic [3:0] exp_ctrl;
        // Leave RUN with a valid word so the underflow count stays at 5.
        s_data  = 10'h00F;
        s_valid = 1'b1;
        locked  = 1'b0;
        step();
        s_valid = 1'b0;
        locked  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
        end
        tests_run++;
        if ({ser_rst, ser_oce, running} !== 3'b010) begin
            tests_failed++;
            $display("FAIL abort_in_train: got rst/oce/run=%b want 010",
                     {ser_rst, ser_oce, running});
        end
        locked = 1'b0;
        for (int k = 41; k <= 45; k++) begin
            step();
            tests_run++;
            if ({ser_rst, ser_oce, running} !== 3'b100) begin
                tests_failed++;
                $display("FAIL abort_idle c%0d: got %b want 100", k,
                         {ser_rst, ser_oce, running});
            end
        end
        locked = 1'b1;
        for (int k = 1; k <= 77; k++) begin
            step();
            exp_ctrl = {(k <= 4), (k >= 13), (k >= 77), (k >= 77)};
            tests_run++;
            if ({ser_rst, ser_oce, s_ready, running} !== exp_ctrl) begin
                tests_failed++;
                $display("FAIL abort_relock c%0d: got %b want %b", k,
                         {ser_rst, ser_oce, s_ready, running}, exp_ctrl);
            end
        end
        tests_run++;
        if (underflow_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL abort_uf: got %h want 0005", underflow_cnt);
        end
    endtask

    task automatic test_saturate();
        s_valid = 1'b0;
        force dut.underflow_cnt_q = 16'hFFFE;
        #1;
        release dut.underflow_cnt_q;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (underflow_cnt !== 16'hFFFF) begin
                tests_failed++;
                $display("FAIL saturate%0d: got %h want ffff", i, underflow_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ser_rst, ser_oce, s_ready, running} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL async_ctrl: got %b want 1000",
                     {ser_rst, ser_oce, s_ready, running});
        end
        tests_run++;
        if (ser_data !== 10'd0) begin
            tests_failed++;
            $display("FAIL async_data: got %h want 000", ser_data);
        end
        tests_run++;
        if (underflow_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_uf: got %h want 0000", underflow_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_startup();
        test_stream();
        test_underflow();
        test_lock_loss();
        test_abort_train();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
